// File: rtl/lc3_instr_prefetch.sv
// Prefetch queue between LC3 instruction memory and Decode, one read in flight.
// Latency: a response captured at one edge is visible at the head after that edge; Decode backpressure stops refetch when all slots are full.
module lc3_instr_prefetch #(
  parameter logic [15:0] START_PC = 16'h3000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        instrmem_rd,
  output logic [15:0] pc,
  input  logic        complete_instr,
  input  logic [15:0] Instr_dout,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] npc,
  input  logic        instr_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  count, count_nxt, count_after_pop;
  logic [AW-1:0]  rptr, wptr, rptr_inc;
  logic [15:0]    pc_nxt, pc_inc;
  logic           push, pop;

  logic [15:0]    q_instr [DEPTH];
  logic [15:0]    q_npc   [DEPTH];

  // A redirect hides the head so Decode cannot consume a word being flushed.
  assign instr_valid     = (count != '0) && !br_taken;
  assign pop             = instr_valid && instr_ready;
  assign push            = (state == REQ) && complete_instr && !br_taken;
  assign pc_inc          = pc + 16'd1;
  assign rptr_inc        = rptr + AW'(1);
  assign count_after_pop = count - CW'(pop);
  assign count_nxt       = count_after_pop + CW'(push);
  assign instrmem_rd     = (state == REQ);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (br_taken) begin
      pc_nxt = taddr;
    end else if (push) begin
      pc_nxt = pc_inc;
    end

    unique case (state)
      IDLE: begin
        if (br_taken || (count_nxt < CW'(DEPTH))) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (br_taken) begin
          state_nxt = complete_instr ? REQ : DISCARD;
        end else if (complete_instr) begin
          state_nxt = (count_nxt < CW'(DEPTH)) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        // The stale response has landed; a same-cycle redirect only retargets pc.
        if (complete_instr) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= START_PC;
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      instr <= '0;
      npc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (br_taken) begin
        count <= '0;
        rptr  <= '0;
        wptr  <= '0;
      end else begin
        count <= count_nxt;
        if (push) begin
          wptr <= wptr + AW'(1);
        end
        if (pop) begin
          rptr <= rptr_inc;
        end
        // Head registers track the next oldest entry; they hold when the queue drains.
        if (pop && (count_after_pop != '0)) begin
          instr <= q_instr[rptr_inc];
          npc   <= q_npc[rptr_inc];
        end else if (push && (count_after_pop == '0)) begin
          instr <= Instr_dout;
          npc   <= pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_instr[wptr] <= Instr_dout;
      q_npc[wptr]   <= pc_inc;
    end
  end

endmodule

// File: tb/tb_lc3_instr_prefetch.sv
// Randomized bench: a latency-programmable memory model plus a transaction-level
// queue model predicting fetch addresses, head contents and instr_valid.
module tb_lc3_instr_prefetch;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic        complete_instr = 1'b0;
  logic [15:0] Instr_dout = '0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] npc;
  logic        instr_ready = 1'b0;

  lc3_instr_prefetch #(.START_PC(16'h3000), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .complete_instr (complete_instr),
    .Instr_dout     (Instr_dout),
    .br_taken       (br_taken),
    .taddr          (taddr),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .npc            (npc),
    .instr_ready    (instr_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  logic [31:0] q[$];
  logic [15:0] exp_fetch;
  logic [31:0] last_head;
  bit          pend, stale;
  int          lat_cnt;
  logic [15:0] paddr;
  int          ready_pct, br_pct, lat_max, pops;
  bit          force_br;
  logic [15:0] force_taddr;

  function automatic logic [15:0] memword(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hC3A5;
  endfunction

  task automatic model_clear();
    q.delete();
    exp_fetch = 16'h3000;
    last_head = '0;
    pend      = 1'b0;
    stale     = 1'b0;
    lat_cnt   = 0;
  endtask

  task automatic step();
    bit          deliver, bt, rdy, popped;
    logic [15:0] ta;
    @(negedge clock);
    deliver = 1'b0;
    if (pend) begin
      lat_cnt--;
      if (lat_cnt == 0) deliver = 1'b1;
    end
    if (pend && instrmem_rd) chk("pc_hold", {16'h0, pc}, {16'h0, paddr});
    if (!pend && instrmem_rd) begin
      chk("req_pc", {16'h0, pc}, {16'h0, exp_fetch});
      pend    = 1'b1;
      stale   = 1'b0;
      paddr   = pc;
      lat_cnt = $urandom_range(lat_max, 1);
    end
    bt = force_br || ($urandom_range(99, 0) < br_pct);
    ta = force_br ? force_taddr : 16'($urandom);
    force_br = 1'b0;
    rdy = ($urandom_range(99, 0) < ready_pct);

    complete_instr = deliver;
    Instr_dout     = deliver ? memword(paddr) : 16'($urandom);
    br_taken       = bt;
    taddr          = ta;
    instr_ready    = rdy;
    #1;

    chk("valid", {31'h0, instr_valid}, {31'h0, (q.size() > 0) && !bt});
    if (q.size() > 0) begin
      last_head = q[0];
      chk("head", {instr, npc}, q[0]);
    end else begin
      chk("hold", {instr, npc}, last_head);
    end
    popped = (q.size() > 0) && !bt && rdy;
    if (popped) begin
      pops++;
      void'(q.pop_front());
    end
    if (deliver) begin
      pend = 1'b0;
      if (!stale && !bt) begin
        chk("no_overflow", {31'h0, q.size() < DEPTH}, 32'h1);
        q.push_back({memword(paddr), paddr + 16'd1});
        exp_fetch = paddr + 16'd1;
      end
    end
    if (bt) begin
      q.delete();
      exp_fetch = ta;
      if (pend) stale = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rd"},    {31'h0, instrmem_rd}, 32'h0);
    chk({tag, "_pc"},    {16'h0, pc},          32'h3000);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_instr"}, {16'h0, instr},       32'h0);
    chk({tag, "_npc"},   {16'h0, npc},         32'h0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("first_req_rd", {31'h0, instrmem_rd}, 32'h1);
    chk("first_req_pc", {16'h0, pc}, 32'h3000);
  endtask

  initial begin
    pops = 0; force_br = 1'b0; force_taddr = '0;
    ready_pct = 100; br_pct = 0; lat_max = 1;
    model_clear();
    #12;
    check_reset_values("rst");
    release_reset();

    // In-order streaming with a 1-cycle memory
    run(30);

    // Decode stalled: queue fills and fetching stops
    ready_pct = 0;
    run(25);
    chk("full_rd",    {31'h0, instrmem_rd}, 32'h0);
    chk("full_valid", {31'h0, instr_valid}, 32'h1);
    chk("full_pc",    {16'h0, pc}, {16'h0, exp_fetch});
    ready_pct = 100;
    run(20);

    // Slow memory, then a redirect while a read is outstanding
    lat_max = 3;
    run(20);
    force_br = 1'b1; force_taddr = 16'h3050;
    run(30);

    // Address wrap at the top of memory
    ready_pct = 0;
    force_br = 1'b1; force_taddr = 16'hFFFE;
    run(20);
    ready_pct = 100;
    run(10);

    // Mixed random traffic
    lat_max = 4; ready_pct = 60; br_pct = 6;
    run(3000);

    // Asynchronous reset mid-stream
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    complete_instr = 1'b0; br_taken = 1'b0; instr_ready = 1'b0;
    repeat (2) @(negedge clock);
    model_clear();
    release_reset();
    run(300);

    chk("progress", {31'h0, pops > 200}, 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
